// File: rtl/merger_pkg.sv
// Shared definitions for the two-input streaming merge stage.
// Key width, the reserved run terminator value and the key type live here
// so the top and the output register agree on them.
package merger_pkg;

    localparam int DATA_WIDTH = 32;

    typedef logic [DATA_WIDTH-1:0] key_t;

    // Zero is reserved: it never appears as a real key and closes every run.
    localparam key_t TERMINATOR = '0;

    // True when a head word is the end-of-run marker.
    function automatic logic is_term(input key_t k);
        return (k == TERMINATOR);
    endfunction

endpackage : merger_pkg

// File: rtl/merger_out_reg.sv
// Output register of the merge stage with valid/ready advance logic.
// The register advances whenever it is empty or the downstream FIFO takes
// the current word; on an advance it either captures a new word or goes
// empty. Writes are suppressed while reset is held low.
module merger_out_reg
    import merger_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load_valid,
    input  key_t i_load_data,
    input  logic i_ready,
    output logic o_adv,
    output logic o_write,
    output key_t o_data
);

    logic valid_q;
    logic valid_d;
    key_t data_q;
    key_t data_d;

    // Advance when nothing is held or the held word leaves this cycle.
    assign o_adv   = (~valid_q) | i_ready;
    assign o_write = valid_q & i_ready & i_rst_n;
    assign o_data  = data_q;

    // Next-state of the output register: load or drain on advance, hold otherwise.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (o_adv) begin
            valid_d = i_load_valid;
            if (i_load_valid) begin
                data_d = i_load_data;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Output register state with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= TERMINATOR;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule : merger_out_reg

// File: rtl/merger.sv
// Two-input streaming merge stage for the sorting datapath.
// Merges pairs of ascending zero-terminated runs from two FWFT FIFOs into
// one ascending run plus a single terminator. Apart from the output
// register the block is stateless: run boundaries come only from
// terminator heads, and when one side sits at its terminator the other
// side drains until both terminators can be popped together.
// Optional build macro MERGER_STATS_EN adds o_run_count, a wrapping count
// of terminators written downstream.
module merger
    import merger_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_fifo_1,
    input  logic                  i_fifo_1_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_2,
    input  logic                  i_fifo_2_empty,
    input  logic                  i_fifo_out_ready,
    output logic                  o_fifo_1_read,
    output logic                  o_fifo_2_read,
    output logic                  o_out_fifo_write,
    output logic [DATA_WIDTH-1:0] o_data
`ifdef MERGER_STATS_EN
    ,
    output logic [15:0]           o_run_count
`endif
);

    logic adv_s;
    logic pop1_s;
    logic pop2_s;
    logic load_valid_s;
    key_t load_data_s;
    logic a_term_s;
    logic b_term_s;

    assign a_term_s = is_term(i_fifo_1);
    assign b_term_s = is_term(i_fifo_2);

    // Compare/select: pick which head(s) to pop and what to load this cycle.
    always_comb begin
        pop1_s       = 1'b0;
        pop2_s       = 1'b0;
        load_valid_s = 1'b0;
        load_data_s  = TERMINATOR;
        if (i_rst_n && adv_s && !i_fifo_1_empty && !i_fifo_2_empty) begin
            load_valid_s = 1'b1;
            case ({a_term_s, b_term_s})
                2'b00: begin
                    // Ties go to FIFO 1; the FIFO 2 copy follows next decision.
                    if (i_fifo_1 <= i_fifo_2) begin
                        pop1_s      = 1'b1;
                        load_data_s = i_fifo_1;
                    end else begin
                        pop2_s      = 1'b1;
                        load_data_s = i_fifo_2;
                    end
                end
                2'b01: begin
                    // FIFO 2 parked on its terminator: drain FIFO 1.
                    pop1_s      = 1'b1;
                    load_data_s = i_fifo_1;
                end
                2'b10: begin
                    // FIFO 1 parked on its terminator: drain FIFO 2.
                    pop2_s      = 1'b1;
                    load_data_s = i_fifo_2;
                end
                2'b11: begin
                    // Both runs finished: one terminator for the pair.
                    pop1_s      = 1'b1;
                    pop2_s      = 1'b1;
                    load_data_s = TERMINATOR;
                end
                default: begin
                    pop1_s       = 1'b0;
                    pop2_s       = 1'b0;
                    load_valid_s = 1'b0;
                    load_data_s  = TERMINATOR;
                end
            endcase
        end else begin
            pop1_s       = 1'b0;
            pop2_s       = 1'b0;
            load_valid_s = 1'b0;
            load_data_s  = TERMINATOR;
        end
    end

    assign o_fifo_1_read = pop1_s;
    assign o_fifo_2_read = pop2_s;

    merger_out_reg u_out_reg (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load_valid (load_valid_s),
        .i_load_data  (load_data_s),
        .i_ready      (i_fifo_out_ready),
        .o_adv        (adv_s),
        .o_write      (o_out_fifo_write),
        .o_data       (o_data)
    );

`ifdef MERGER_STATS_EN
    logic [15:0] run_count_q;
    logic [15:0] run_count_d;

    // Count terminators actually written downstream; wraps naturally.
    always_comb begin
        run_count_d = run_count_q;
        if (o_out_fifo_write && is_term(o_data)) begin
            run_count_d = run_count_q + 16'd1;
        end else begin
            run_count_d = run_count_q;
        end
    end

    // Run counter register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            run_count_q <= 16'd0;
        end else begin
            run_count_q <= run_count_d;
        end
    end

    assign o_run_count = run_count_q;
`endif

endmodule : merger

// File: tb/tb_merger.sv
// Self-checking bench for merger: directed scenarios plus randomized runs
// checked against a sort-based reference model of the merged output.
module tb_merger;
    import merger_pkg::*;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic i_rst_n;
    key_t i_fifo_1;
    logic i_fifo_1_empty;
    key_t i_fifo_2;
    logic i_fifo_2_empty;
    logic i_fifo_out_ready;
    logic o_fifo_1_read;
    logic o_fifo_2_read;
    logic o_out_fifo_write;
    key_t o_data;
`ifdef MERGER_STATS_EN
    logic [15:0] o_run_count;
`endif

    merger dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_fifo_1         (i_fifo_1),
        .i_fifo_1_empty   (i_fifo_1_empty),
        .i_fifo_2         (i_fifo_2),
        .i_fifo_2_empty   (i_fifo_2_empty),
        .i_fifo_out_ready (i_fifo_out_ready),
        .o_fifo_1_read    (o_fifo_1_read),
        .o_fifo_2_read    (o_fifo_2_read),
        .o_out_fifo_write (o_out_fifo_write),
        .o_data           (o_data)
`ifdef MERGER_STATS_EN
        ,
        .o_run_count      (o_run_count)
`endif
    );

    key_t q1[$];
    key_t q2[$];
    key_t got[$];
    key_t exp_q[$];
    key_t run_a[$];
    key_t run_b[$];
    logic stall1;
    logic stall2;
    int   checks = 0;
    int   passes = 0;
    logic s_r1;
    logic s_r2;
    logic s_w;
    key_t s_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive_heads();
        i_fifo_1_empty = (q1.size() == 0) || stall1;
        i_fifo_2_empty = (q2.size() == 0) || stall2;
        i_fifo_1 = (q1.size() != 0) ? q1[0] : 32'hFFFF_FFFF;
        i_fifo_2 = (q2.size() != 0) ? q2[0] : 32'hFFFF_FFFF;
    endtask

    // One clock: drive, sample mid-cycle, then apply pops/writes after the edge.
    task automatic tick(input logic rdy);
        i_fifo_out_ready = rdy;
        drive_heads();
        @(negedge i_clk);
        s_r1 = o_fifo_1_read;
        s_r2 = o_fifo_2_read;
        s_w  = o_out_fifo_write;
        s_d  = o_data;
        if (i_fifo_1_empty) check("pop1_while_empty", {31'd0, s_r1}, 32'd0);
        if (i_fifo_2_empty) check("pop2_while_empty", {31'd0, s_r2}, 32'd0);
        if (!rdy) check("write_without_ready", {31'd0, s_w}, 32'd0);
        @(posedge i_clk);
        #1;
        if (s_r1 && q1.size() > 0) q1.delete(0);
        if (s_r2 && q2.size() > 0) q2.delete(0);
        if (s_w) got.push_back(s_d);
    endtask

    task automatic run_until(input int n, input int budget, input logic rnd);
        int cyc;
        cyc = 0;
        while (got.size() < n && cyc < budget) begin
            if (rnd) begin
                stall1 = ($urandom_range(3, 0) == 0);
                stall2 = ($urandom_range(3, 0) == 0);
                tick($urandom_range(3, 0) != 0);
            end else begin
                tick(1'b1);
            end
            cyc++;
        end
        stall1 = 1'b0;
        stall2 = 1'b0;
        check("run_complete_words", got.size(), n);
    endtask

    task automatic compare_got(input string tag);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) check(tag, got[i], exp_q[i]);
        end
    endtask

    // Reference: each run pair becomes the sorted union of both runs, then 0.
    task automatic add_pair(input int len_a, input int len_b);
        key_t v;
        int idx;
        run_a.delete();
        run_b.delete();
        for (int i = 0; i < len_a; i++) begin
            v = $urandom_range(20, 1);
            idx = 0;
            while (idx < run_a.size() && run_a[idx] <= v) idx++;
            run_a.insert(idx, v);
        end
        for (int i = 0; i < len_b; i++) begin
            v = $urandom_range(20, 1);
            idx = 0;
            while (idx < run_b.size() && run_b[idx] <= v) idx++;
            run_b.insert(idx, v);
        end
        foreach (run_a[i]) q1.push_back(run_a[i]);
        foreach (run_b[i]) q2.push_back(run_b[i]);
        q1.push_back(TERMINATOR);
        q2.push_back(TERMINATOR);
        foreach (run_b[i]) run_a.push_back(run_b[i]);
        run_a.sort();
        foreach (run_a[i]) exp_q.push_back(run_a[i]);
        exp_q.push_back(TERMINATOR);
    endtask

    initial begin
        int total;
        i_rst_n = 1'b0;
        i_fifo_out_ready = 1'b1;
        stall1 = 1'b0;
        stall2 = 1'b0;
        drive_heads();
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        check("reset_write", {31'd0, o_out_fifo_write}, 32'd0);
        check("reset_data", o_data, 32'd0);
`ifdef MERGER_STATS_EN
        check("reset_run_count", {16'd0, o_run_count}, 32'd0);
`endif
        i_rst_n = 1'b1;

        // Interleaved runs: one word per cycle, 1-cycle latency.
        q1 = '{32'd1, 32'd3, 32'd5, 32'd7, 32'd0};
        q2 = '{32'd2, 32'd4, 32'd6, 32'd8, 32'd0};
        got.delete();
        tick(1'b1);
        check("t1_first_pop1", {31'd0, s_r1}, 32'd1);
        check("t1_first_no_write", {31'd0, s_w}, 32'd0);
        tick(1'b1);
        check("t1_latency_write", {31'd0, s_w}, 32'd1);
        check("t1_latency_data", s_d, 32'd1);
        for (int i = 0; i < 8; i++) tick(1'b1);
        check("t1_throughput_words", got.size(), 32'd9);
        tick(1'b1);
        check("t1_idle_no_write", {31'd0, s_w}, 32'd0);
        exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd0};
        compare_got("t1_data");

        // Empty runs on both sides: a single terminator.
        q1 = '{32'd0};
        q2 = '{32'd0};
        got.delete();
        tick(1'b1);
        check("t2_pop1", {31'd0, s_r1}, 32'd1);
        check("t2_pop2", {31'd0, s_r2}, 32'd1);
        tick(1'b1);
        check("t2_write", {31'd0, s_w}, 32'd1);
        check("t2_data", s_d, 32'd0);
        tick(1'b1);
`ifdef MERGER_STATS_EN
        check("t2_run_count", {16'd0, o_run_count}, 32'd2);
`endif

        // FIFO 1 finishes first, FIFO 2 drains while FIFO 1 waits at 0.
        q1 = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
        q2 = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd0};
        got.delete();
        run_until(9, 40, 1'b0);
        exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd0};
        compare_got("t3_data");

        // Equal keys: FIFO 1 first, then FIFO 2.
        q1 = '{32'd5, 32'd0};
        q2 = '{32'd5, 32'd0};
        got.delete();
        tick(1'b1);
        check("t4_first_pop1", {31'd0, s_r1}, 32'd1);
        check("t4_first_nopop2", {31'd0, s_r2}, 32'd0);
        tick(1'b1);
        check("t4_second_nopop1", {31'd0, s_r1}, 32'd0);
        check("t4_second_pop2", {31'd0, s_r2}, 32'd1);
        run_until(3, 20, 1'b0);
        exp_q = '{32'd5, 32'd5, 32'd0};
        compare_got("t4_data");

        // Back-pressure mid-stream: data holds, no writes, no pops.
        q1 = '{32'd10, 32'd20, 32'd30, 32'd0};
        q2 = '{32'd15, 32'd25, 32'd0};
        got.delete();
        tick(1'b1);
        tick(1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            check("t5_hold_data", s_d, 32'd15);
            check("t5_hold_nopop1", {31'd0, s_r1}, 32'd0);
            check("t5_hold_nopop2", {31'd0, s_r2}, 32'd0);
        end
        run_until(6, 40, 1'b0);
        exp_q = '{32'd10, 32'd15, 32'd20, 32'd25, 32'd30, 32'd0};
        compare_got("t5_data");

        // Reset mid-run discards the output register.
        q1 = '{32'd3, 32'd9, 32'd0};
        q2 = '{32'd4, 32'd0};
        got.delete();
        tick(1'b1);
        tick(1'b1);
        i_rst_n = 1'b0;
        drive_heads();
        @(negedge i_clk);
        check("t6_rst_write", {31'd0, o_out_fifo_write}, 32'd0);
        check("t6_rst_pop1", {31'd0, o_fifo_1_read}, 32'd0);
        check("t6_rst_pop2", {31'd0, o_fifo_2_read}, 32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        q1.delete();
        q2.delete();
        tick(1'b1);
        check("t6_after_rst_write", {31'd0, s_w}, 32'd0);
`ifdef MERGER_STATS_EN
        check("t6_run_count", {16'd0, o_run_count}, 32'd0);
`endif

        // Randomized run pairs with random stalls and back-pressure.
        got.delete();
        exp_q.delete();
        for (int p = 0; p < 8; p++) add_pair($urandom_range(6, 0), $urandom_range(6, 0));
        total = exp_q.size();
        run_until(total, 4000, 1'b1);
        compare_got("rand_data");
        check("rand_q1_drained", q1.size(), 32'd0);
        check("rand_q2_drained", q2.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_merger

// File: doc/merger.md
# merger

Two-input streaming merge stage for the sorting datapath. It consumes two first-word-fall-through input FIFOs, each holding ascending runs of unsigned keys, each run ending in a zero terminator. It emits one merged ascending run per pair of input runs, followed by a single zero terminator, into an output FIFO. It sits between two upstream FIFOs and one downstream FIFO in the merge tree.

## Interface
- DATA_WIDTH, 32, key width; value 0 is reserved as the run terminator.
- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  reset, synchronous and active-low.
- i_fifo_1  in  DATA_WIDTH  head of input FIFO 1; valid when i_fifo_1_empty is low.
- i_fifo_1_empty  in  1  input FIFO 1 has no data.
- i_fifo_2  in  DATA_WIDTH  head of input FIFO 2.
- i_fifo_2_empty  in  1  input FIFO 2 has no data.
- i_fifo_out_ready  in  1  output FIFO accepts a write at this edge (not full, or being read).
- o_fifo_1_read  out  1  pop FIFO 1 at this edge; combinational.
- o_fifo_2_read  out  1  pop FIFO 2 at this edge; combinational.
- o_out_fifo_write  out  1  push o_data at this edge.
- o_data  out  DATA_WIDTH  registered output word.

## Operation
- Output register: out_data and out_valid. The register advances ("adv") when out_valid is 0 or i_fifo_out_ready is 1.
- o_out_fifo_write = out_valid & i_fifo_out_ready. o_data = out_data.
- A decision is made only when adv = 1 and both inputs are non-empty. Otherwise there are no pops, and out_valid is cleared if adv = 1.
- Decision rules, where a and b are the two heads:
  - a≠0, b≠0, a≤b: pop 1, load a.
  - a≠0, b≠0, a>b: pop 2, load b.
  - a≠0, b=0: pop 1, load a. This drains FIFO 1 while FIFO 2 waits at its terminator.
  - a=0, b≠0: pop 2, load b.
  - a=0, b=0: pop both, load 0. This emits one terminator per run pair.
- Equal non-zero keys: FIFO 1 goes first. The FIFO 2 key follows on the next decision.
- The block is stateless apart from the output register. Run boundaries are derived purely from terminator heads.
- At most one word is output per cycle. Pops are never issued while an input is empty.
- Input ordering is not checked. Unsorted runs produce unsorted output with no error flag.

## Timing
- Reset (i_rst_n=0 at an edge): out_valid=0, out_data=0. o_out_fifo_write, o_fifo_1_read and o_fifo_2_read are 0 while reset is asserted.
- Latency is 1 cycle: a word popped at edge N appears as o_data with o_out_fifo_write after edge N.
- Throughput is 1 word per cycle when inputs are available and ready is held high.
- Back-pressure: if ready=0 while out_valid=1, out_data holds, write is 0 and no pops occur.
- Reset mid-run discards the output register. The input FIFOs are not reset by this block.

## Configuration
- MERGER_STATS_EN defined:
  - Adds output o_run_count[15:0].
  - Resets to 0 and increments on each written terminator (o_out_fifo_write & o_data==0).
  - Wraps at 0xFFFF→0.
- MERGER_STATS_EN undefined: the port and counter are absent. Merge behaviour is identical in both builds.

## Structure
- Shared package merger_pkg holds DATA_WIDTH, TERMINATOR = '0, and the key typedef.
- One sub-module, merger_out_reg: the output register with the valid/ready advance logic.
- The compare/select logic lives in the top module.

## Test plan
- Stream FIFO1 = 1,3,5,7,0 and FIFO2 = 2,4,6,8,0 with ready=1 → outputs 1,2,3,4,5,6,7,8,0, one per cycle, first word 1 cycle after the first pop.
- Both FIFOs = 0 (empty runs) → a single 0 output, both popped in the same cycle.
- FIFO1 = 1,2,3,4,0 and FIFO2 = 5,6,7,8,0 → 1..4, then 5..8 drained from FIFO2 while FIFO1 waits at 0, then 0. Total 9 writes.
- Equal keys: FIFO1 = 5,0 and FIFO2 = 5,0 → 5 (FIFO1 popped), 5 (FIFO2 popped), 0.
- Hold ready=0 for 3 cycles mid-stream → o_data is stable, no writes and no pops. The stream resumes with no loss or duplication.
- Assert reset mid-run → o_out_fifo_write=0 the next cycle. With MERGER_STATS_EN, o_run_count=0 after reset and equals 2 after the first two bullets.
